// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port round-robin arbiter in front of a single-cycle-latency RAM.
//   Each port issues one request at a time. It gets one response, read or write,
//   two cycles after the request is accepted. The response is held until the
//   consumer takes it.
//
//   Ports:
//     clk, reset            - sole clock; synchronous active-high reset
//     pN_rq_valid/ready/rq  - port N request {addr[64:33], iswrite[32], wdata[31:0]}
//     pN_rs_valid/ready/rs  - port N response (read data / pre-write contents)
//     ram_rq_en/addr/we/wdata - RAM access strobe, byte address, write enable/data
//     ram_rs_en/rdata       - RAM read data, valid one cycle after ram_rq_en
//     err/err_addr          - sticky out-of-range flag and first offending address
// -----------------------------------------------------------------------------

// Per-port request/response sequencer. It walks IDLE -> WAIT -> HOLD and holds
// the response register until the consumer takes it.
module mem_arbiter_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        grant,     // request accepted this cycle
    input  logic        cap_en,    // this port owns the RAM data returning now
    input  logic [31:0] cap_data,  // RAM data or 0 for out-of-range requests
    input  logic        rs_ready,
    output logic        idle,
    output logic        rs_valid,
    output logic [31:0] rs
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = WAIT;
            WAIT:    state_d = HOLD;
            HOLD:    if (rs_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The response register keeps its value once the handshake is done. It is
    // only rewritten by the next request's capture.
    always_ff @(posedge clk) begin
        if (reset)                         rs <= 32'h0;
        else if (state_q == WAIT && cap_en) rs <= cap_data;
    end

    assign idle     = (state_q == IDLE);
    assign rs_valid = (state_q == HOLD);
endmodule

module mem_arbiter #(
    parameter int LGSZW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_rq_valid,
    output logic             p0_rq_ready,
    input  logic [64:0]      p0_rq,
    output logic             p0_rs_valid,
    input  logic             p0_rs_ready,
    output logic [31:0]      p0_rs,
    input  logic             p1_rq_valid,
    output logic             p1_rq_ready,
    input  logic [64:0]      p1_rq,
    output logic             p1_rs_valid,
    input  logic             p1_rs_ready,
    output logic [31:0]      p1_rs,
    output logic             ram_rq_en,
    output logic [LGSZW+1:0] ram_addr,
    output logic             ram_we,
    output logic [31:0]      ram_wdata,
    input  logic             ram_rs_en,
    input  logic [31:0]      ram_rdata,
    output logic             err,
    output logic [31:0]      err_addr
);
    localparam int AW = LGSZW + 2;

    logic [1:0]        rq_valid, rs_ready, rs_valid, idle, elig, gnt, cap_en;
    logic [1:0][64:0]  rq;
    logic [1:0][31:0]  rs;

    logic        gsel;       // index of granted port (valid when |gnt)
    logic [64:0] sel_rq;
    logic [31:0] sel_addr;
    logic        in_range;

    logic        last_grant;
    logic        own_vld, own_port, own_inr;
    logic [31:0] cap_data;

    assign rq_valid = {p1_rq_valid, p0_rq_valid};
    assign rs_ready = {p1_rs_ready, p0_rs_ready};
    assign rq       = {p1_rq, p0_rq};

    assign p0_rq_ready = gnt[0];
    assign p1_rq_ready = gnt[1];
    assign p0_rs_valid = rs_valid[0];
    assign p1_rs_valid = rs_valid[1];
    assign p0_rs       = rs[0];
    assign p1_rs       = rs[1];

    // Arbitration: on a tie the port that did not win last time goes first.
    always_comb begin
        elig = rq_valid & idle;
        gnt  = 2'b00;
        if (!reset) begin
            if (elig == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
            else               gnt = elig;
        end
    end

    assign gsel     = gnt[1];
    assign sel_rq   = rq[gsel];
    assign sel_addr = sel_rq[64:33];
    assign in_range = ((sel_addr >> AW) == 32'd0);

    // Out-of-range requests never reach the RAM, so their writes are dropped.
    assign ram_rq_en = (|gnt) && in_range;
    assign ram_we    = ram_rq_en && sel_rq[32];
    assign ram_addr  = sel_addr[AW-1:0];
    assign ram_wdata = sel_rq[31:0];

    // The owner register tracks whose RAM response arrives next cycle. A
    // ram_rs_en that no access of ours produced is ignored because own_vld is
    // clear. This includes the one right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            own_vld    <= 1'b0;
            own_port   <= 1'b0;
            own_inr    <= 1'b0;
            err        <= 1'b0;
            err_addr   <= 32'h0;
        end else begin
            own_vld <= |gnt;
            if (|gnt) begin
                own_port   <= gsel;
                own_inr    <= in_range;
                last_grant <= gsel;
                if (!in_range && !err) begin
                    err      <= 1'b1;
                    err_addr <= sel_addr;
                end
            end
        end
    end

    assign cap_data = (own_inr && ram_rs_en) ? ram_rdata : 32'h0;

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign cap_en[i] = own_vld && (own_port == 1'(i));

        mem_arbiter_port u_port (
            .clk      (clk),
            .reset    (reset),
            .grant    (gnt[i]),
            .cap_en   (cap_en[i]),
            .cap_data (cap_data),
            .rs_ready (rs_ready[i]),
            .idle     (idle[i]),
            .rs_valid (rs_valid[i]),
            .rs       (rs[i])
        );
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. It keeps a timestamp-based reference model
// of both ports, a byte-array RAM behind the DUT, and per-port expected-response
// queues that a separate monitor drains.
module tb_mem_arbiter;
    localparam int LGSZW = 8;
    localparam int MEMSZ = 1 << (LGSZW + 2);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             p0_rq_valid = 1'b0, p1_rq_valid = 1'b0;
    logic             p0_rq_ready, p1_rq_ready;
    logic [64:0]      p0_rq = '0, p1_rq = '0;
    logic             p0_rs_valid, p1_rs_valid;
    logic             p0_rs_ready = 1'b0, p1_rs_ready = 1'b0;
    logic [31:0]      p0_rs, p1_rs;
    logic             ram_rq_en, ram_we;
    logic [LGSZW+1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic             ram_rs_en = 1'b0;
    logic [31:0]      ram_rdata = '0;
    logic             err;
    logic [31:0]      err_addr;

    mem_arbiter #(.LGSZW(LGSZW)) dut (
        .clk(clk), .reset(reset),
        .p0_rq_valid(p0_rq_valid), .p0_rq_ready(p0_rq_ready), .p0_rq(p0_rq),
        .p0_rs_valid(p0_rs_valid), .p0_rs_ready(p0_rs_ready), .p0_rs(p0_rs),
        .p1_rq_valid(p1_rq_valid), .p1_rq_ready(p1_rq_ready), .p1_rq(p1_rq),
        .p1_rs_valid(p1_rs_valid), .p1_rs_ready(p1_rs_ready), .p1_rs(p1_rs),
        .ram_rq_en(ram_rq_en), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rs_en(ram_rs_en), .ram_rdata(ram_rdata),
        .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    logic        rqv[2], rqr[2], rsv[2], rsr[2];
    logic [64:0] rqd[2];
    logic [31:0] rsd[2];
    assign rqv[0] = p0_rq_valid; assign rqv[1] = p1_rq_valid;
    assign rqr[0] = p0_rq_ready; assign rqr[1] = p1_rq_ready;
    assign rsv[0] = p0_rs_valid; assign rsv[1] = p1_rs_valid;
    assign rsr[0] = p0_rs_ready; assign rsr[1] = p1_rs_ready;
    assign rqd[0] = p0_rq;       assign rqd[1] = p1_rq;
    assign rsd[0] = p0_rs;       assign rsd[1] = p1_rs;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s port%0d: got %h, expected %h (t=%0t)", nm, p, act, exp, $time);
        end
    endtask

    // Two byte memories. ram_mem sits behind the DUT. ref_mem is the model's view.
    logic [7:0] ram_mem[MEMSZ];
    logic [7:0] ref_mem[MEMSZ];

    function automatic logic [31:0] ref_rd(input int a);
        return {ref_mem[(a+3)%MEMSZ], ref_mem[(a+2)%MEMSZ], ref_mem[(a+1)%MEMSZ], ref_mem[a%MEMSZ]};
    endfunction
    task automatic ref_wr(input int a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) ref_mem[(a+k)%MEMSZ] = d[8*k +: 8];
    endtask
    function automatic logic [31:0] ram_rd(input int a);
        return {ram_mem[(a+3)%MEMSZ], ram_mem[(a+2)%MEMSZ], ram_mem[(a+1)%MEMSZ], ram_mem[a%MEMSZ]};
    endfunction
    task automatic ram_wr(input int a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) ram_mem[(a+k)%MEMSZ] = d[8*k +: 8];
    endtask

    // RAM: returns pre-write contents one cycle after the strobe. When idle it
    // sometimes raises ram_rs_en with junk, which the DUT must ignore.
    logic        ram_ne;
    logic [31:0] ram_nd;
    always begin : ram_model
        @(negedge clk);
        if (ram_rq_en === 1'b1) begin
            ram_nd = ram_rd(int'(ram_addr));
            if (ram_we) ram_wr(int'(ram_addr), ram_wdata);
            ram_ne = 1'b1;
        end else begin
            ram_ne = ($urandom_range(7) == 0);
            ram_nd = $urandom;
        end
        @(posedge clk);
        #1;
        ram_rs_en = ram_ne;
        ram_rdata = ram_nd;
    end

    // Reference model. A port is busy from its accept until its response is
    // taken, and its response is due two cycles after the accept.
    logic        busy[2];
    int          acc[2];
    int          cyc = 0;
    int          last = 1;
    logic        err_m = 1'b0;
    logic [31:0] err_addr_m = '0;
    bit          post_rst = 1'b0;
    logic [31:0] q0[$], q1[$];

    always @(negedge clk) begin : model
        logic        elig[2];
        logic        hs[2];
        int          g;
        logic [31:0] ad, ex;
        logic        inr;
        cyc++;
        if (reset) begin
            chk("rst_rq_ready", 0, 32'(p0_rq_ready), 0);
            chk("rst_rq_ready", 1, 32'(p1_rq_ready), 0);
            chk("rst_ram_rq_en", 0, 32'(ram_rq_en), 0);
            chk("rst_ram_we", 0, 32'(ram_we), 0);
            busy[0] = 1'b0; busy[1] = 1'b0;
            last = 1; err_m = 1'b0; err_addr_m = '0;
            q0.delete(); q1.delete();
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("post_rst_rs", 0, p0_rs, 0);
                chk("post_rst_rs", 1, p1_rs, 0);
                post_rst = 1'b0;
            end
            chk("err", 0, 32'(err), 32'(err_m));
            chk("err_addr", 0, err_addr, err_addr_m);
            for (int i = 0; i < 2; i++) begin
                logic ev;
                ev = busy[i] && (cyc >= acc[i] + 2);
                chk("rs_valid", i, 32'(rsv[i]), 32'(ev));
                hs[i]   = ev && rsr[i];
                elig[i] = rqv[i] && !busy[i];
            end
            if (elig[0] && elig[1]) g = 1 - last;
            else if (elig[0])       g = 0;
            else if (elig[1])       g = 1;
            else                    g = -1;
            chk("rq_ready", 0, 32'(p0_rq_ready), 32'(g == 0));
            chk("rq_ready", 1, 32'(p1_rq_ready), 32'(g == 1));
            if (g >= 0) begin
                ad  = rqd[g][64:33];
                inr = (ad < 32'(MEMSZ));
                chk("ram_rq_en", g, 32'(ram_rq_en), 32'(inr));
                chk("ram_we", g, 32'(ram_we), 32'(inr && rqd[g][32]));
                if (inr) begin
                    chk("ram_addr", g, 32'(ram_addr), ad);
                    chk("ram_wdata", g, ram_wdata, rqd[g][31:0]);
                    ex = ref_rd(int'(ad));
                    if (rqd[g][32]) ref_wr(int'(ad), rqd[g][31:0]);
                end else begin
                    ex = 32'h0;
                    if (!err_m) begin err_m = 1'b1; err_addr_m = ad; end
                end
                if (g == 0) q0.push_back(ex); else q1.push_back(ex);
                busy[g] = 1'b1;
                acc[g]  = cyc;
                last    = g;
            end else begin
                chk("idle_ram_rq_en", 0, 32'(ram_rq_en), 0);
                chk("idle_ram_we", 0, 32'(ram_we), 0);
            end
            for (int i = 0; i < 2; i++) if (hs[i]) busy[i] = 1'b0;
        end
    end

    // Monitor: pops the expected data on every response handshake and checks
    // that a response stalled by backpressure does not change.
    logic        hold_v[2];
    logic [31:0] hold_d[2];
    initial begin hold_v[0] = 1'b0; hold_v[1] = 1'b0; end
    always @(negedge clk) begin : monitor
        #1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                hold_v[i] = 1'b0;
            end else if (rsv[i]) begin
                if (hold_v[i]) chk("rs_stable", i, rsd[i], hold_d[i]);
                if (rsr[i]) begin
                    int sz;
                    logic [31:0] ex;
                    sz = (i == 0) ? q0.size() : q1.size();
                    chk("rs_expected", i, 32'(sz > 0), 1);
                    if (sz > 0) begin
                        ex = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk("rs_data", i, rsd[i], ex);
                    end
                end
                hold_v[i] = !rsr[i];
                hold_d[i] = rsd[i];
            end else begin
                hold_v[i] = 1'b0;
            end
        end
    end

    task automatic step(input logic rst,
                        input logic v0, input logic [31:0] a0, input logic w0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                        input logic r0, input logic r1);
        @(posedge clk);
        #1;
        reset = rst;
        p0_rq_valid = v0; p0_rq = {a0, w0, d0};
        p1_rq_valid = v1; p1_rq = {a1, w1, d1};
        p0_rs_ready = r0; p1_rs_ready = r1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    function automatic logic [31:0] raddr();
        if ($urandom_range(7) == 0) return $urandom | 32'h400;
        return 32'($urandom_range(MEMSZ - 1));
    endfunction

    initial begin
        for (int k = 0; k < MEMSZ; k++) begin
            ram_mem[k] = 8'($urandom);
            ref_mem[k] = ram_mem[k];
        end
        ram_mem[8] = 8'h44; ram_mem[9] = 8'h33; ram_mem[10] = 8'h22; ram_mem[11] = 8'h11;
        ref_mem[8] = 8'h44; ref_mem[9] = 8'h33; ref_mem[10] = 8'h22; ref_mem[11] = 8'h11;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // p0 reads 0x8 alone, then both ports request back to back.
        step(0, 1, 32'h8, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        for (int k = 0; k < 8; k++) step(0, 1, raddr() & 32'h3FF, 0, 0, 1, raddr() & 32'h3FF, 0, 0, 1, 1);
        idle(3);
        // Unaligned write, then read it back.
        step(0, 1, 32'h3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1);
        idle(3);
        step(0, 1, 32'h3, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        // Out-of-range write, then a second out-of-range read.
        step(0, 0, 0, 0, 0, 1, 32'h400, 1, 32'hCAFEF00D, 1, 1);
        idle(3);
        step(0, 0, 0, 0, 0, 1, 32'h800, 0, 0, 1, 1);
        idle(3);
        // p0 stalls its response while p1 keeps working.
        for (int k = 0; k < 9; k++) step(0, 1, 32'h10, 0, 0, 1, raddr() & 32'h3FF, 0, 0, 0, 1);
        idle(4);
        // Reset while p0 is in WAIT, then p0 is served again.
        step(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 32'h24, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(4);
        // Random traffic.
        for (int k = 0; k < 3000; k++)
            step(($urandom_range(299) == 0),
                 ($urandom_range(3) != 0), raddr(), 1'($urandom), $urandom,
                 ($urandom_range(3) != 0), raddr(), 1'($urandom), $urandom,
                 ($urandom_range(3) != 0), ($urandom_range(3) != 0));
        idle(6);
        @(negedge clk);
        #2;
        chk("drained", 0, 32'(q0.size()), 0);
        chk("drained", 1, 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LGSZW, default 8, log2 of RAM size in 32-bit words; RAM window is byte addresses 0 .. 2^(LGSZW+2)-1.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pN_rq_valid  in  1  port N (N=0,1) request valid.
REQ-006 pN_rq_ready  out  1  port N request accepted this cycle.
REQ-007 pN_rq  in  65  {addr[64:33], iswrite[32], wdata[31:0]}.
REQ-008 pN_rs_valid  out  1  port N response valid.
REQ-009 pN_rs_ready  in  1  port N consumer accepts response.
REQ-010 pN_rs  out  32  port N response data.
REQ-011 ram_rq_en  out  1  RAM access strobe.
REQ-012 ram_addr  out  LGSZW+2  RAM byte address, any alignment.
REQ-013 ram_we  out  1  RAM write enable.
REQ-014 ram_wdata  out  32  RAM write data.
REQ-015 ram_rs_en  in  1  RAM read data valid, exactly 1 cycle after ram_rq_en.
REQ-016 ram_rdata  in  32  RAM read data (pre-write contents on a write).
REQ-017 err  out  1  sticky out-of-range access flag.
REQ-018 err_addr  out  32  address of first out-of-range access.

Function
REQ-019 Per-port FSM: IDLE -> WAIT on accept; WAIT -> HOLD unconditionally next cycle; HOLD -> IDLE on pN_rs_valid && pN_rs_ready.
REQ-020 Port eligible iff pN_rq_valid && state==IDLE; at most one grant per cycle; pN_rq_ready = grant to N (combinational).
REQ-021 Both eligible: grant port != last_grant; last_grant updates on every grant; single eligible port granted regardless of last_grant.
REQ-022 In-range (addr >> (LGSZW+2) == 0): same cycle ram_rq_en=1, ram_we=iswrite, ram_addr=addr[LGSZW+1:0], ram_wdata=wdata.
REQ-023 Out-of-range: ram_rq_en=0, ram_we=0, write dropped; response data 32'h0.
REQ-024 No grant: ram_rq_en=0, ram_we=0; ram_addr/ram_wdata don't-care.
REQ-025 Owner register records granted port and in-range bit; in WAIT, owner port captures ram_rdata (in-range) or 0 into pN_rs.
REQ-026 Latency: accept at cycle N -> pN_rs_valid=1 from cycle N+2; every request, read or write, yields exactly one response.
REQ-027 pN_rs_valid and pN_rs held stable while pN_rs_ready=0; pN_rq_ready=0 throughout WAIT/HOLD.
REQ-028 Port may re-request in the cycle after its response handshake (min 3-cycle per-port period); other port unaffected by backpressure.
REQ-029 ram_rs_en with no request issued in prior cycle: ignored.
REQ-030 err set on first out-of-range accept, err_addr captures its address; both held until reset; later errors don't overwrite.

Reset
REQ-031 During reset cycle no grants: pN_rq_ready=0, ram_rq_en=0, ram_we=0.
REQ-032 After reset: both FSMs IDLE, pN_rs_valid=0, pN_rs=0, err=0, err_addr=0, last_grant=1 (port 0 wins first tie).
REQ-033 Reset mid-operation: outstanding/held responses discarded; ram_rs_en in the cycle after reset ignored.

Verification
REQ-034 p0 read addr 0x8, RAM word 0x11223344 -> cycle N ram_rq_en=1, ram_addr=0x8, ram_we=0; p0_rs_valid=1, p0_rs=0x11223344 at N+2.
REQ-035 Both ports request continuously after reset, rs_ready=1 -> grant order p0, p1, p0, p1 (cycles N, N+1, N+3, N+4).
REQ-036 p1 write addr 0x400, LGSZW=8 -> no ram_rq_en; err=1, err_addr=0x400 at N+1; p1_rs=0 at N+2; second bad addr 0x800 leaves err_addr=0x400.
REQ-037 p0 rs_ready=0 for 5 cycles -> p0_rs_valid/p0_rs stable, p0_rq_ready=0; p1 read issued and completed meanwhile.
REQ-038 p0 write 0xDEADBEEF to addr 0x3, then read 0x3 -> read returns 0xDEADBEEF; write response equals prior contents.
REQ-039 reset asserted while p0 in WAIT -> next cycle p0_rs_valid=0, p0_rq_ready=0, err=0; following p0 request served normally.
